pipeline_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage pipelined CPU.
- Drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Sequences them around imem misses, dmem waits, load-use hazards, taken branches/jumps and halt.
- Holds a small RUN/MEMWAIT/HALT state machine and saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 28 ++
 rtl/pipeline_hazard_ctrl_if.sv | 52 +++++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// The control bundle keeps the eight latch controls together so priority cases assign them as one word.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } hzstate_t;

    localparam logic [4:0] ZERO_REG = 5'd0;

    // Bit order is pc, IF/ID, ID/EX, EX/MEM, MEM/WB enables, then IF/ID, ID/EX, MEM/WB flushes.
    typedef struct packed {
        logic pcEn;
        logic ifidEn;
        logic idexEn;
        logic exmemEn;
        logic memwbEn;
        logic ifidFlush;
        logic idexFlush;
        logic memwbFlush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN    = 8'b11111_000;
    localparam hz_ctrl_t CTRL_FREEZE = 8'b00000_000;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The controller connects through 'master', since it drives every latch control.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);

    logic             ihit;
    logic             dhit;
    logic             mem_dren;
    logic             mem_dwen;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_wsel;
    logic             ex_branch_taken;
    logic             id_jump;
    logic             wb_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    hzstate_t         hz_state;

    modport master (
        input  ihit, dhit, mem_dren, mem_dwen, id_rs, id_rt, id_uses_rt,
               ex_memread, ex_wsel, ex_branch_taken, id_jump, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, halted,
               stall_cnt, flush_cnt, hz_state
    );

    modport slave (
        output ihit, dhit, mem_dren, mem_dwen, id_rs, id_rt, id_uses_rt,
               ex_memread, ex_wsel, ex_branch_taken, id_jump, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, halted,
               stall_cnt, flush_cnt, hz_state
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// The counter holds at all-ones rather than wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Latch controls are combinational from state and hazard inputs; only state, halted and counters are registered.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    pipeline_hazard_ctrl_if.master hz
);

    hzstate_t  state_q;
    hzstate_t  state_d;
    logic      halted_q;
    logic      halted_d;
    hz_ctrl_t  ctrl;
    logic      loadUse;
    logic      dwait;
    logic      stallInc;
    logic      flushInc;

    // A load into $0 never creates a real dependency.
    assign loadUse = hz.ex_memread
                   && (hz.ex_wsel != REG_W'(ZERO_REG))
                   && ((hz.ex_wsel == hz.id_rs)
                       || (hz.id_uses_rt && (hz.ex_wsel == hz.id_rt)));

    assign dwait = (hz.mem_dren || hz.mem_dwen) && !hz.dhit;

    always_comb begin
        ctrl    = CTRL_RUN;
        state_d = state_q;
        if (state_q == HALT) begin
            ctrl    = CTRL_FREEZE;
            state_d = HALT;
        end else begin
            state_d = RUN;
            if (hz.wb_halt) begin
                ctrl    = CTRL_FREEZE;
                state_d = HALT;
            end else if (dwait) begin
                ctrl.pcEn       = 1'b0;
                ctrl.ifidEn     = 1'b0;
                ctrl.idexEn     = 1'b0;
                ctrl.exmemEn    = 1'b0;
                ctrl.memwbFlush = 1'b1;
                state_d         = MEMWAIT;
            end else if (hz.ex_branch_taken) begin
                ctrl.ifidFlush = 1'b1;
                ctrl.idexFlush = 1'b1;
            end else if (loadUse) begin
                ctrl.pcEn      = 1'b0;
                ctrl.ifidEn    = 1'b0;
                ctrl.idexFlush = 1'b1;
            end else if (hz.id_jump) begin
                // A jump fetched alongside an imem miss must still hold the PC.
                ctrl.pcEn      = hz.ihit;
                ctrl.ifidFlush = 1'b1;
            end else if (!hz.ihit) begin
                ctrl.pcEn      = 1'b0;
                ctrl.ifidFlush = 1'b1;
            end
        end
    end

    assign halted_d = (state_d == HALT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign stallInc = (state_q != HALT) && !ctrl.pcEn;
    assign flushInc = (state_q != HALT) && (ctrl.ifidFlush || ctrl.idexFlush);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (CLK),
        .rst (RST),
        .inc (stallInc),
        .clr (1'b0),
        .cnt (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (CLK),
        .rst (RST),
        .inc (flushInc),
        .clr (1'b0),
        .cnt (hz.flush_cnt)
    );

    assign hz.pc_en       = ctrl.pcEn;
    assign hz.ifid_en     = ctrl.ifidEn;
    assign hz.idex_en     = ctrl.idexEn;
    assign hz.exmem_en    = ctrl.exmemEn;
    assign hz.memwb_en    = ctrl.memwbEn;
    assign hz.ifid_flush  = ctrl.ifidFlush;
    assign hz.idex_flush  = ctrl.idexFlush;
    assign hz.memwb_flush = ctrl.memwbFlush;
    assign hz.halted      = halted_q;
    assign hz.hz_state    = state_q;

endmodule
